fetch_buffer: RTL



---
 rtl/fetch_buffer.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/fetch_buffer.sv
// -----------------------------------------------------------------------------
// fetch_buffer
//
// Dual-issue instruction queue between fetch and decode. Up to two fetched
// instructions per cycle, each with its PC and predicted-taken bit, are
// written into a circular buffer. The two oldest entries are presented to the
// decoder pair in program order. A flush discards the whole buffer.
//
// Parameters:
//   DEPTH            number of single-instruction entries (power of two, >= 4)
//
// Ports:
//   clk_i            clock, all state updates on the rising edge
//   rst_n_i          asynchronous active-low reset
//   flush_i          discard all entries (priority over enqueue/dequeue)
//   stall_i          decode cannot accept, no dequeue this cycle
//   fetch_valid*_i   fetch slot 0/1 carries an instruction
//   fetch_inst*_i    fetch slot instruction words
//   fetch_pc*_i      fetch slot PCs
//   fetch_pred*_i    fetch slot predicted-taken bits
//   fetch_ready_o    buffer can accept two instructions this cycle
//   inst*_o          oldest / second-oldest instruction (NOP when invalid)
//   pc*_o            matching PCs (0 when invalid)
//   pred_taken_*_o   matching prediction bits (0 when invalid)
//   valid*_o         decode slot holds a real instruction
//   count_o          current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module fetch_buffer #(
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     flush_i,
    input  logic                     stall_i,
    input  logic                     fetch_valid0_i,
    input  logic                     fetch_valid1_i,
    input  logic [31:0]              fetch_inst0_i,
    input  logic [31:0]              fetch_inst1_i,
    input  logic [31:0]              fetch_pc0_i,
    input  logic [31:0]              fetch_pc1_i,
    input  logic                     fetch_pred0_i,
    input  logic                     fetch_pred1_i,
    output logic                     fetch_ready_o,
    output logic [31:0]              inst0_o,
    output logic [31:0]              inst1_o,
    output logic [31:0]              pc0_o,
    output logic [31:0]              pc1_o,
    output logic                     pred_taken_0_o,
    output logic                     pred_taken_1_o,
    output logic                     valid0_o,
    output logic                     valid1_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    // Storage (not reset: validity is tracked by count only)
    logic [31:0] inst_mem_r [DEPTH];
    logic [31:0] pc_mem_r   [DEPTH];
    logic        pred_mem_r [DEPTH];

    // Pointers and occupancy
    logic [PW-1:0] head_r;
    logic [PW-1:0] tail_r;
    logic [CW-1:0] count_r;

    // Enqueue / dequeue control
    logic          ready_s;
    logic          enq_ok_s;
    logic [1:0]    n_enq_s;
    logic [1:0]    n_deq_s;
    logic [PW-1:0] tail_plus1_s;
    logic [PW-1:0] head_plus1_s;
    logic [CW-1:0] count_next_s;

    // Compacted write data: wr0 goes to tail, wr1 goes to tail+1
    logic [31:0]   wr0_inst_s;
    logic [31:0]   wr0_pc_s;
    logic          wr0_pred_s;
    logic [31:0]   wr1_inst_s;
    logic [31:0]   wr1_pc_s;
    logic          wr1_pred_s;

    // Read-side validity
    logic          rd0_valid_s;
    logic          rd1_valid_s;

    // Ready depends on registered count only, never on the same-cycle dequeue
    always_comb begin
        ready_s      = (count_r <= CW'(DEPTH - 2));
        enq_ok_s     = ready_s && !flush_i;
        tail_plus1_s = tail_r + PW'(1);
        head_plus1_s = head_r + PW'(1);
    end

    // Enqueue compaction: pack valid fetch slots into consecutive entries and
    // drop slot 1 when slot 0 is predicted taken (slot 1 is then wrong-path)
    always_comb begin
        n_enq_s    = 2'd0;
        wr0_inst_s = fetch_inst0_i;
        wr0_pc_s   = fetch_pc0_i;
        wr0_pred_s = fetch_pred0_i;
        wr1_inst_s = fetch_inst1_i;
        wr1_pc_s   = fetch_pc1_i;
        wr1_pred_s = fetch_pred1_i;
        if (enq_ok_s) begin
            case ({fetch_valid0_i, fetch_valid1_i})
                2'b10: begin
                    n_enq_s = 2'd1;
                end
                2'b01: begin
                    n_enq_s    = 2'd1;
                    wr0_inst_s = fetch_inst1_i;
                    wr0_pc_s   = fetch_pc1_i;
                    wr0_pred_s = fetch_pred1_i;
                end
                2'b11: begin
                    if (fetch_pred0_i) begin
                        n_enq_s = 2'd1;
                    end else begin
                        n_enq_s = 2'd2;
                    end
                end
                default: begin
                    n_enq_s = 2'd0;
                end
            endcase
        end else begin
            n_enq_s = 2'd0;
        end
    end

    // Dequeue up to two entries unless stalled; count is 0 or 1 below two
    always_comb begin
        n_deq_s = 2'd0;
        if (stall_i) begin
            n_deq_s = 2'd0;
        end else if (count_r >= CW'(2)) begin
            n_deq_s = 2'd2;
        end else begin
            n_deq_s = {1'b0, count_r[0]};
        end
        count_next_s = count_r + CW'(n_enq_s) - CW'(n_deq_s);
    end

    // Pointer and occupancy registers; flush wins over enqueue and dequeue
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            head_r  <= {PW{1'b0}};
            tail_r  <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
        end else if (flush_i) begin
            head_r  <= {PW{1'b0}};
            tail_r  <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
        end else begin
            head_r  <= head_r + PW'(n_deq_s);
            tail_r  <= tail_r + PW'(n_enq_s);
            count_r <= count_next_s;
        end
    end

    // Entry storage writes at tail and tail+1
    always_ff @(posedge clk_i) begin
        if (n_enq_s != 2'd0) begin
            inst_mem_r[tail_r] <= wr0_inst_s;
            pc_mem_r[tail_r]   <= wr0_pc_s;
            pred_mem_r[tail_r] <= wr0_pred_s;
        end
        if (n_enq_s == 2'd2) begin
            inst_mem_r[tail_plus1_s] <= wr1_inst_s;
            pc_mem_r[tail_plus1_s]   <= wr1_pc_s;
            pred_mem_r[tail_plus1_s] <= wr1_pred_s;
        end
    end

    // Decode-side view: reads of head/head+1 gated by registered count, so
    // the outputs depend on state only and invalid slots show NOP/0/0
    always_comb begin
        rd0_valid_s = (count_r != {CW{1'b0}});
        rd1_valid_s = (count_r >= CW'(2));

        valid0_o       = rd0_valid_s;
        valid1_o       = rd1_valid_s;
        inst0_o        = NOP_INST;
        pc0_o          = 32'h0000_0000;
        pred_taken_0_o = 1'b0;
        inst1_o        = NOP_INST;
        pc1_o          = 32'h0000_0000;
        pred_taken_1_o = 1'b0;

        if (rd0_valid_s) begin
            inst0_o        = inst_mem_r[head_r];
            pc0_o          = pc_mem_r[head_r];
            pred_taken_0_o = pred_mem_r[head_r];
        end else begin
            inst0_o        = NOP_INST;
            pc0_o          = 32'h0000_0000;
            pred_taken_0_o = 1'b0;
        end

        if (rd1_valid_s) begin
            inst1_o        = inst_mem_r[head_plus1_s];
            pc1_o          = pc_mem_r[head_plus1_s];
            pred_taken_1_o = pred_mem_r[head_plus1_s];
        end else begin
            inst1_o        = NOP_INST;
            pc1_o          = 32'h0000_0000;
            pred_taken_1_o = 1'b0;
        end

        fetch_ready_o = ready_s;
        count_o       = count_r;
    end

endmodule
